// File: rtl/axi_stream_rr_arbiter.sv
// Packet-level round-robin arbiter: shares one AXI-Stream master channel among
// NUM_SLAVES requesters, holding each grant from first beat through last.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant held; outputs quiet; picks next requester from rr_ptr
// BUSY  | grant_id owns the master channel until its last beat transfers
module axi_stream_rr_arbiter #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int ID_WIDTH       = $clog2(NUM_SLAVES)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SLAVES*AXI_DATA_WIDTH-1:0] slave_data_in,
    input  logic [NUM_SLAVES-1:0]                slave_valid_in,
    input  logic [NUM_SLAVES-1:0]                slave_last_in,
    output logic [NUM_SLAVES-1:0]                slave_ready_in,
    output logic [AXI_DATA_WIDTH-1:0]            master_data_out,
    output logic                                 master_valid_out,
    output logic                                 master_last_out,
    input  logic                                 master_ready_out,
    output logic                                 grant_valid,
    output logic [ID_WIDTH-1:0]                  grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Wrap limit carries one extra bit so rr_ptr + offset cannot overflow.
    localparam logic [ID_WIDTH:0]   NUM_WRAP = (ID_WIDTH + 1)'(NUM_SLAVES);
    localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(NUM_SLAVES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [ID_WIDTH-1:0] grant_id_nxt;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] rr_ptr_nxt;

    logic                sel_found;
    logic [ID_WIDTH-1:0] sel_idx;
    logic [ID_WIDTH:0]   cand;
    logic                last_xfer;

    logic [AXI_DATA_WIDTH-1:0] data_arr [NUM_SLAVES];

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_unpack
        assign data_arr[i] = slave_data_in[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end

    // Final beat of the granted packet is transferring this cycle.
    assign last_xfer = (state == BUSY) && slave_valid_in[grant_id]
                       && slave_last_in[grant_id] && master_ready_out;

    // Pick the first valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            cand = {1'b0, rr_ptr} + k[ID_WIDTH:0];
            if (cand >= NUM_WRAP) begin
                cand = cand - NUM_WRAP;
            end
            if (!sel_found && slave_valid_in[cand[ID_WIDTH-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[ID_WIDTH-1:0];
            end
        end
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_id_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

    // Next-state: grant on any request in IDLE, release after the last beat.
    always_comb begin
        state_nxt    = state;
        grant_id_nxt = grant_id;
        rr_ptr_nxt   = rr_ptr;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt    = BUSY;
                    grant_id_nxt = sel_idx;
                end
            end
            BUSY: begin
                if (last_xfer) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: zero-latency mux of the granted requester while BUSY.
    always_comb begin
        slave_ready_in   = '0;
        master_data_out  = '0;
        master_valid_out = 1'b0;
        master_last_out  = 1'b0;
        grant_valid      = 1'b0;
        if (state == BUSY) begin
            grant_valid              = 1'b1;
            master_data_out          = data_arr[grant_id];
            master_valid_out         = slave_valid_in[grant_id];
            master_last_out          = slave_last_in[grant_id];
            slave_ready_in[grant_id] = master_ready_out;
        end
    end

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Directed bench for axi_stream_rr_arbiter with a beat scoreboard.
module tb_axi_stream_rr_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] slave_data_in;
    logic [N-1:0]   slave_valid_in;
    logic [N-1:0]   slave_last_in;
    logic [N-1:0]   slave_ready_in;
    logic [W-1:0]   master_data_out;
    logic           master_valid_out;
    logic           master_last_out;
    logic           master_ready_out;
    logic           grant_valid;
    logic [1:0]     grant_id;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    beat_t exp_q[$];
    int    beat_cyc[$];

    axi_stream_rr_arbiter #(.AXI_DATA_WIDTH(W), .NUM_SLAVES(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .slave_data_in    (slave_data_in),
        .slave_valid_in   (slave_valid_in),
        .slave_last_in    (slave_last_in),
        .slave_ready_in   (slave_ready_in),
        .master_data_out  (master_data_out),
        .master_valid_out (master_valid_out),
        .master_last_out  (master_last_out),
        .master_ready_out (master_ready_out),
        .grant_valid      (grant_valid),
        .grant_id         (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [31:0] d, input logic l);
        beat_t b;
        b.id = id;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Monitor: every handshake on the master side is popped and compared.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst && master_valid_out && master_ready_out) begin
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %0h id %0d expected none", master_data_out, grant_id);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", master_data_out, b.data);
                    check("beat_last", 32'(master_last_out), 32'(b.last));
                    check("beat_id", 32'(grant_id), 32'(b.id));
                end
            end
        end
    end

    task automatic send_beat(input int s, input logic [31:0] d, input logic l);
        int   t;
        logic hs;
        slave_valid_in[s] = 1'b1;
        slave_data_in[s*W +: W] = d;
        slave_last_in[s] = l;
        t = 0;
        hs = 1'b0;
        while (!hs && t < 300) begin
            @(negedge clk);
            hs = slave_ready_in[s];
            @(posedge clk);
            #1;
            t++;
        end
        if (!hs) begin
            n_vec++;
            n_err++;
            $display("FAIL handshake_timeout: slave %0d got no ready, required ready within 300 cycles", s);
        end
        slave_valid_in[s] = 1'b0;
        slave_last_in[s] = 1'b0;
    endtask

    task automatic send_pkt(input int s, input int n, input logic [31:0] base, input int gap);
        for (int b = 0; b < n; b++) begin
            send_beat(s, base + 32'(b), (b == n - 1));
            if (b != n - 1) repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        repeat (4) @(posedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        slave_valid_in = '0;
        slave_last_in = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int t;
        logic done1;

        rst = 1'b0;
        slave_data_in = '0;
        slave_valid_in = '0;
        slave_last_in = '0;
        master_ready_out = 1'b0;

        // Reset: requests present while held in reset must be ignored.
        repeat (2) @(posedge clk);
        #1 slave_valid_in = 4'hF;
        @(negedge clk);
        check("rst_ready", 32'(slave_ready_in), 32'd0);
        check("rst_mvalid", 32'(master_valid_out), 32'd0);
        check("rst_gvalid", 32'(grant_valid), 32'd0);
        check("rst_mdata", master_data_out, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rel_gvalid_idle", 32'(grant_valid), 32'd0);
        @(negedge clk);
        check("rel_gvalid", 32'(grant_valid), 32'd1);
        check("rel_gid", 32'(grant_id), 32'd0);
        @(posedge clk);
        #1 do_reset();

        // Round-robin: four 2-beat packets, order 0..3, one idle cycle between.
        master_ready_out = 1'b1;
        for (int i = 0; i < N; i++) begin
            push(i, 32'hA0 + 32'(i), 1'b0);
            push(i, 32'hB0 + 32'(i), 1'b1);
        end
        beat_cyc.delete();
        fork
            begin send_beat(0, 32'hA0, 1'b0); send_beat(0, 32'hB0, 1'b1); end
            begin send_beat(1, 32'hA1, 1'b0); send_beat(1, 32'hB1, 1'b1); end
            begin send_beat(2, 32'hA2, 1'b0); send_beat(2, 32'hB2, 1'b1); end
            begin send_beat(3, 32'hA3, 1'b0); send_beat(3, 32'hB3, 1'b1); end
        join
        drain("rr_drain");
        check("rr_beats", 32'(beat_cyc.size()), 32'd8);
        if (beat_cyc.size() == 8) begin
            for (int k = 1; k < 8; k++) begin
                check("rr_spacing", 32'(beat_cyc[k] - beat_cyc[k-1]), (k % 2 == 1) ? 32'd1 : 32'd2);
            end
        end

        // Packet lock: slave 1 gapped packet finishes before slave 2 gets in.
        for (int b = 0; b < 4; b++) push(1, 32'hC0 + 32'(b), (b == 3));
        push(2, 32'hD2, 1'b1);
        bad = 0;
        done1 = 1'b0;
        fork
            begin send_pkt(1, 4, 32'hC0, 2); done1 = 1'b1; end
            send_beat(2, 32'hD2, 1'b1);
            begin
                while (!done1) begin
                    @(negedge clk);
                    if (slave_ready_in[2]) bad++;
                end
            end
        join
        check("lock_ready2", 32'(bad), 32'd0);
        drain("lock_drain");

        // Backpressure: ready pattern 1,0,0,1 on a 3-beat slave 3 packet.
        for (int b = 0; b < 3; b++) push(3, 32'hE0 + 32'(b), (b == 2));
        fork
            send_pkt(3, 3, 32'hE0, 0);
            begin
                t = 0;
                while (!grant_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                check("bp_grant", 32'(grant_id), 32'd3);
                @(posedge clk);
                #1 master_ready_out = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    @(negedge clk);
                    check("bp_stall_data", master_data_out, 32'hE1);
                    check("bp_stall_last", 32'(master_last_out), 32'd0);
                    check("bp_stall_valid", 32'(master_valid_out), 32'd1);
                    @(posedge clk);
                    #1;
                end
                master_ready_out = 1'b1;
            end
        join
        drain("bp_drain");

        // Wrap fairness: pointer wrapped past 3, so slave 0 precedes slave 2.
        push(0, 32'hF0, 1'b1);
        push(2, 32'hF2, 1'b1);
        fork
            send_beat(0, 32'hF0, 1'b1);
            send_beat(2, 32'hF2, 1'b1);
        join
        drain("wrap_drain");

        // Mid-packet reset: abandon slave 0 packet on beat 2, restart from 0.
        push(0, 32'h50, 1'b0);
        slave_valid_in[0] = 1'b1;
        slave_data_in[0 +: W] = 32'h50;
        slave_last_in[0] = 1'b0;
        t = 0;
        bad = 0;
        while (bad == 0 && t < 50) begin
            @(negedge clk);
            if (slave_ready_in[0]) bad = 1;
            t++;
        end
        check("mid_first_ready", 32'(bad), 32'd1);
        @(posedge clk);
        #1 slave_data_in[0 +: W] = 32'h51;
        #2 rst = 1'b0;
        #1;
        check("mid_mvalid", 32'(master_valid_out), 32'd0);
        check("mid_gvalid", 32'(grant_valid), 32'd0);
        check("mid_ready", 32'(slave_ready_in), 32'd0);
        check("mid_mdata", master_data_out, 32'd0);
        check("mid_mlast", 32'(master_last_out), 32'd0);
        slave_valid_in = '0;
        slave_last_in = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        push(2, 32'h72, 1'b1);
        send_beat(2, 32'h72, 1'b1);
        drain("mid_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
